sel_mux_pipe: RTL

- Parametrised N-to-1 operand select stage for the OOO-OTTER datapath.
- Generalises the fixed-width combinational selectors to NUM_IN inputs of WIDTH bits.
- The selected word is captured into a 2-entry elastic buffer with valid/ready handshakes on both sides, so operand selection can sit on a registered pipeline boundary (e.g. issue to execute).
- Out-of-range selects are flagged rather than silently aliased.

---
 rtl/sel_mux_pipe_if.sv | 29 ++
 rtl/sel_mux_pipe.sv | 110 +++++++++++
 2 files changed

// File: rtl/sel_mux_pipe_if.sv
// Handshake bundle for sel_mux_pipe: the upstream select/capture side and the
// downstream head-of-buffer side.
interface sel_mux_pipe_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 6,
    parameter int SEL_W  = 3
);
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_sel_err;
    logic                    out_valid;
    logic                    out_ready;
    logic [1:0]              occupancy;

    // Driver / monitor side (testbench, upstream and downstream stages).
    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_sel_err, out_valid, occupancy
    );

    // Block side.
    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_sel_err, out_valid, occupancy
    );
endinterface

// File: rtl/sel_mux_pipe.sv
// N-to-1 operand select feeding a 2-entry elastic buffer. Out-of-range selects
// capture input 0 and carry an error flag with the entry.
module sel_mux_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 6,
    parameter int SEL_W  = 3
) (
    input logic           CLK,
    input logic           RST,
    sel_mux_pipe_if.slave pipe
);

    generate
        if ((NUM_IN < 2) || (NUM_IN > 16) || ((1 << SEL_W) < NUM_IN)) begin : g_bad_params
            $fatal(1, "sel_mux_pipe: illegal NUM_IN/SEL_W combination");
        end
    endgenerate

    logic [WIDTH-1:0]  r_head;
    logic              r_head_err;
    logic [WIDTH-1:0]  r_tail;
    logic              r_tail_err;
    logic [1:0]        r_occ;

    logic [NUM_IN-1:0] w_hit;
    logic [WIDTH-1:0]  w_sel_data;
    logic [WIDTH-1:0]  w_cap_data;
    logic              w_cap_err;
    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_push;
    logic              w_pop;

    // One-hot decode of the select; an index past NUM_IN matches nothing.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            w_hit[i] = (pipe.in_sel == i[SEL_W-1:0]);
        end
    end

    // AND-OR mux so unselected inputs (even X) are masked to zero.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            w_sel_data = w_sel_data | (pipe.in_data[i*WIDTH +: WIDTH] & {WIDTH{w_hit[i]}});
        end
    end

    // Out-of-range select falls back to input 0 and flags the entry.
    always_comb begin
        w_cap_err = ~(|w_hit);
        if (w_cap_err) begin
            w_cap_data = pipe.in_data[WIDTH-1:0];
        end else begin
            w_cap_data = w_sel_data;
        end
    end

    // Ready depends only on registered fill level and reset, never on out_ready.
    always_comb begin
        w_in_ready  = (r_occ != 2'd2) & ~RST;
        w_out_valid = (r_occ != 2'd0);
        w_push      = pipe.in_valid & w_in_ready;
        w_pop       = w_out_valid & pipe.out_ready;
    end

    // Buffer storage and fill counter; tail shifts into head when the head is popped.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_occ      <= 2'd0;
            r_head     <= '0;
            r_head_err <= 1'b0;
            r_tail     <= '0;
            r_tail_err <= 1'b0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_head     <= w_cap_data;
                        r_head_err <= w_cap_err;
                    end else begin
                        r_tail     <= w_cap_data;
                        r_tail_err <= w_cap_err;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_head     <= r_tail;
                    r_head_err <= r_tail_err;
                    r_occ      <= r_occ - 2'd1;
                end
                2'b11: begin
                    r_head     <= w_cap_data;
                    r_head_err <= w_cap_err;
                end
                default: begin
                    r_occ <= r_occ;
                end
            endcase
        end
    end

    assign pipe.in_ready    = w_in_ready;
    assign pipe.out_valid   = w_out_valid;
    assign pipe.out_data    = r_head;
    assign pipe.out_sel_err = r_head_err;
    assign pipe.occupancy   = r_occ;

endmodule
